bus_cycle_sequencer: RTL
========================

// Module: bus_cycle_sequencer
// PURPOSE
// Parametrised multiplexed-bus transaction sequencer (successor to the fixed-count AD/CS/RD/WR timing control).
// Accepts one start/busy/done request. Runs a full address phase, then a data phase (write or read).
// Setup/pulse/hold/gap durations, data width and address-skip mode are all configurable.
// Sits between the transaction controller and the external device pins; drives the active-low strobes and the tri-state bus.
// PARAMETERS
// DW       8   bus/address/data width
// CW       5   phase counter width; every T_* must satisfy 1 <= T_* <= 2**CW
// T_SETUP  2   cycles strobes stay high with bus valid, before CS/strobe fall
// T_PULSE  18  cycles CS and strobe held low
// T_HOLD   2   cycles after strobe rise; bus still driven
// T_GAP    4   idle recovery cycles after the data phase (busy stays high)
// PORTS
// clk       in   1   rising-edge clock
// rst       in   1   asynchronous, active-low reset
// start     in   1   request; sampled only in IDLE
// rw        in   1   1 = read, 0 = write; latched with start
// skip_addr in   1   1 = data phase only (reuse last address); latched with start
// addr      in   DW  address; latched with start
// wdata     in   DW  write data; latched with start
// bus_in    in   DW  pad input from external bus
// bus_out   out  DW  pad output data
// bus_oe    out  1   1 = drive bus_out onto pads
// c_ad_n    out  1   0 = address phase
// c_cs_n    out  1   chip select, active low
// c_rd_n    out  1   read strobe, active low
// c_wr_n    out  1   write/latch strobe, active low
// rdata     out  DW  captured read data, held until the next read
// busy      out  1   transaction in progress
// done      out  1   one-cycle pulse at transaction end
// BEHAVIOUR
// - Reset (rst=0, async): state=IDLE. c_*_n=1, bus_oe=0, bus_out=0, rdata=0, busy=0, done=0.
//   Mid-transaction reset aborts at once. No done pulse; the aborted transaction is not resumed.
// - All outputs are registered; no combinational path from inputs to outputs.
// - FSM states: IDLE, A_SETUP, A_PULSE, A_HOLD, D_SETUP, D_PULSE, D_HOLD, GAP.
//   Each timed state lasts its T_* cycles: counter loaded with T_*-1 on entry, leaves when it reaches 0.
// - Entry from IDLE on edge with start=1: go to A_SETUP, or D_SETUP if skip_addr=1.
//   Latch addr/wdata/rw; busy=1 from the next cycle. start while busy=1 is ignored, not queued.
// - Output levels (ad,cs,rd,wr / bus_oe / bus_out):
//   IDLE, GAP: 1,1,1,1 / 0.
//   A_SETUP: 0,1,1,1 / 1 / addr. A_PULSE: 0,0,1,0 / 1 / addr. A_HOLD: 0,1,1,1 / 1 / addr.
//   D_SETUP, D_HOLD: 1,1,1,1 / !rw / wdata.
//   D_PULSE: 1,0,rd=!rw? ,wr -- read: 1,0,0,1 / 0; write: 1,0,1,0 / 1 / wdata.
// - Read capture: rdata <= bus_in on the edge leaving D_PULSE (last pulse cycle). No update on writes.
// - done=1 for exactly the first GAP cycle. busy falls on the edge leaving GAP.
//   A start high on that same edge is not accepted; it is accepted on the next edge, with IDLE lasting one cycle.
// - Busy length: 2*(T_SETUP+T_PULSE+T_HOLD)+T_GAP cycles (48 at defaults).
//   With skip_addr: T_SETUP+T_PULSE+T_HOLD+T_GAP cycles (26 at defaults).
// - Never drives bus_oe=1 while c_rd_n=0.
// TESTING
// - Write, defaults, addr=0x21, wdata=0x5A, start at cycle 0.
//   -> c_ad_n=0 cyc 1-22; c_cs_n/c_wr_n=0 cyc 3-20 and 25-42; bus_out=0x21 cyc 1-22, 0x5A cyc 23-44; done cyc 45; busy=0 cyc 49.
// - Read, addr=0x24, bus_in=0xA7 during D_PULSE.
//   -> c_rd_n=0 cyc 25-42; bus_oe=0 cyc 23-48; rdata=0xA7 from cyc 43; c_wr_n=0 only cyc 3-20.
// - skip_addr=1 read -> c_ad_n stays 1 throughout; c_rd_n=0 cyc 3-20; done cyc 23; busy high 26 cycles.
// - rst=0 asserted during D_PULSE of a write -> same-cycle: all c_*_n=1, bus_oe=0, busy=0; no done; next start runs a full cycle.
// - start held high continuously -> second transaction's A_SETUP begins cyc 50; start pulses during busy produce no extra transaction.
// - T_SETUP=T_PULSE=T_HOLD=T_GAP=1 write -> busy high 7 cycles; c_wr_n=0 cyc 2 and 5; done cyc 7.

Source files
------------

// File: rtl/bus_cycle_sequencer_if.sv
// Controller-side handshake plus external multiplexed-bus pins of the bus cycle sequencer.
// The sequencer uses the slave view; whatever drives requests and pads uses the master view.
interface bus_cycle_sequencer_if #(
  parameter int DW = 8
);
  logic          start;
  logic          rw;
  logic          skip_addr;
  logic [DW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] bus_in;
  logic [DW-1:0] bus_out;
  logic          bus_oe;
  logic          c_ad_n;
  logic          c_cs_n;
  logic          c_rd_n;
  logic          c_wr_n;
  logic [DW-1:0] rdata;
  logic          busy;
  logic          done;

  modport master (
    output start, rw, skip_addr, addr, wdata, bus_in,
    input  bus_out, bus_oe, c_ad_n, c_cs_n, c_rd_n, c_wr_n, rdata, busy, done
  );

  modport slave (
    input  start, rw, skip_addr, addr, wdata, bus_in,
    output bus_out, bus_oe, c_ad_n, c_cs_n, c_rd_n, c_wr_n, rdata, busy, done
  );
endinterface

// File: rtl/bus_cycle_sequencer.sv
// Multiplexed-bus transaction sequencer: address phase, data phase (read or write), then recovery gap.
// Every pin is registered from the next-state decode, so pins switch on the same edge as the state.
module bus_cycle_sequencer #(
  parameter int DW      = 8,
  parameter int CW      = 5,
  parameter int T_SETUP = 2,
  parameter int T_PULSE = 18,
  parameter int T_HOLD  = 2,
  parameter int T_GAP   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bus_cycle_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE, A_SETUP, A_PULSE, A_HOLD, D_SETUP, D_PULSE, D_HOLD, GAP
  } state_t;

  localparam logic [CW-1:0] LD_SETUP = CW'(T_SETUP - 1);
  localparam logic [CW-1:0] LD_PULSE = CW'(T_PULSE - 1);
  localparam logic [CW-1:0] LD_HOLD  = CW'(T_HOLD - 1);
  localparam logic [CW-1:0] LD_GAP   = CW'(T_GAP - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rw_q, rw_d;
  logic [DW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [DW-1:0] bus_out_q, bus_out_d;
  logic          oe_q, oe_d;
  logic          ad_n_q, ad_n_d;
  logic          cs_n_q, cs_n_d;
  logic          rd_n_q, rd_n_d;
  logic          wr_n_q, wr_n_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          last;

  assign last = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    if (state_q != IDLE && !last) cnt_d = cnt_q - 1'b1;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          rw_d    = bus.rw;
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
          state_d = bus.skip_addr ? D_SETUP : A_SETUP;
          cnt_d   = LD_SETUP;
        end
      end
      A_SETUP: if (last) begin state_d = A_PULSE; cnt_d = LD_PULSE; end
      A_PULSE: if (last) begin state_d = A_HOLD;  cnt_d = LD_HOLD;  end
      A_HOLD:  if (last) begin state_d = D_SETUP; cnt_d = LD_SETUP; end
      D_SETUP: if (last) begin state_d = D_PULSE; cnt_d = LD_PULSE; end
      D_PULSE: begin
        if (last) begin
          state_d = D_HOLD;
          cnt_d   = LD_HOLD;
          if (rw_q) rdata_d = bus.bus_in;
        end
      end
      D_HOLD:  if (last) begin state_d = GAP; cnt_d = LD_GAP; end
      GAP:     if (last) begin state_d = IDLE; cnt_d = '0; end
      default: begin state_d = IDLE; cnt_d = '0; end
    endcase
  end

  // Pin levels decoded from the upcoming state; the bus is released for the whole read strobe.
  always_comb begin
    ad_n_d    = 1'b1;
    cs_n_d    = 1'b1;
    rd_n_d    = 1'b1;
    wr_n_d    = 1'b1;
    oe_d      = 1'b0;
    bus_out_d = '0;
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == GAP) && (state_q != GAP);
    case (state_d)
      A_SETUP, A_HOLD: begin
        ad_n_d    = 1'b0;
        oe_d      = 1'b1;
        bus_out_d = addr_d;
      end
      A_PULSE: begin
        ad_n_d    = 1'b0;
        cs_n_d    = 1'b0;
        wr_n_d    = 1'b0;
        oe_d      = 1'b1;
        bus_out_d = addr_d;
      end
      D_SETUP, D_HOLD: begin
        oe_d      = !rw_d;
        bus_out_d = wdata_d;
      end
      D_PULSE: begin
        cs_n_d    = 1'b0;
        bus_out_d = wdata_d;
        if (rw_d) begin
          rd_n_d = 1'b0;
        end else begin
          wr_n_d = 1'b0;
          oe_d   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rw_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      bus_out_q <= '0;
      oe_q      <= 1'b0;
      ad_n_q    <= 1'b1;
      cs_n_q    <= 1'b1;
      rd_n_q    <= 1'b1;
      wr_n_q    <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rw_q      <= rw_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      bus_out_q <= bus_out_d;
      oe_q      <= oe_d;
      ad_n_q    <= ad_n_d;
      cs_n_q    <= cs_n_d;
      rd_n_q    <= rd_n_d;
      wr_n_q    <= wr_n_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.bus_out = bus_out_q;
  assign bus.bus_oe  = oe_q;
  assign bus.c_ad_n  = ad_n_q;
  assign bus.c_cs_n  = cs_n_q;
  assign bus.c_rd_n  = rd_n_q;
  assign bus.c_wr_n  = wr_n_q;
  assign bus.rdata   = rdata_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule
